scazator_16bit_pipe: RTL and testbench

SCAZATOR_16BIT_PIPE -- requirements
Module: scazator_16bit_pipe

---
 rtl/scazator_16bit_pipe_if.sv | 25 ++
 rtl/scazator_16bit_pipe.sv | 125 ++++++++++++
 tb/tb_scazator_16bit_pipe.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scazator_16bit_pipe_if.sv
// Operand/result bundle for the 16-bit pipelined subtractor.
// The master side supplies operands and accepts results; the slave side is the subtractor.
interface scazator_16bit_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/scazator_16bit_pipe.sv
// Two-stage 16-bit subtractor (a - b - bin) with valid/ready flow control.
// Stage 1 registers four 4-bit group sums of a + ~b with their propagate and
// generate bits; stage 2 resolves the group carries with one lookahead level,
// corrects the group sums and registers diff, bout, ovf and zero.
module scazator_16bit_pipe (
    input  logic                  clk,
    input  logic                  rst,
    scazator_16bit_pipe_if.slave  bus
);
    localparam int DATA_W = 16;
    localparam int GRP_W  = 4;
    localparam int NGRP   = DATA_W / GRP_W;

    // Lookahead over the four groups; returns {c16, c12, c8, c4, c0}.
    function automatic logic [NGRP:0] group_carries(
        input logic [NGRP-1:0] p,
        input logic [NGRP-1:0] g,
        input logic            cin
    );
        logic [NGRP:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (&p & cin);
        return c;
    endfunction

    // Stage 1 state
    logic [DATA_W-1:0] sum_p1;
    logic [NGRP-1:0]   p_p1;
    logic [NGRP-1:0]   g_p1;
    logic              cin_p1;
    logic              a15_p1;
    logic              b15_p1;
    logic              vld_p1;

    // Stage 2 (output) state
    logic [DATA_W-1:0] diff_p2;
    logic              bout_p2;
    logic              ovf_p2;
    logic              zero_p2;
    logic              vld_p2;

    // Flow control
    logic s2_load;
    logic s1_load;
    logic in_fire;

    assign s2_load     = !vld_p2 || bus.out_ready;
    assign s1_load     = !vld_p1 || s2_load;
    assign bus.in_ready = s1_load && !rst;
    assign in_fire     = bus.in_valid && bus.in_ready;

    // ---- stage 0 -> 1: raw group sums with group carry-in 0 ----
    logic [DATA_W-1:0] raw_sum;
    logic [NGRP-1:0]   grp_p;
    logic [NGRP-1:0]   grp_g;

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_s1
        logic [GRP_W-1:0] nb;
        logic [GRP_W:0]   gsum;
        assign nb                      = ~bus.b[gi*GRP_W +: GRP_W];
        assign gsum                    = {1'b0, bus.a[gi*GRP_W +: GRP_W]} + {1'b0, nb};
        assign raw_sum[gi*GRP_W +: GRP_W] = gsum[GRP_W-1:0];
        assign grp_g[gi]               = gsum[GRP_W];
        assign grp_p[gi]               = &(bus.a[gi*GRP_W +: GRP_W] ^ nb);
    end

    // ---- stage 1 -> 2: carry resolution and group correction ----
    logic [NGRP:0]     carries;
    logic [DATA_W-1:0] diff_nxt;
    logic              ovf_nxt;

    assign carries = group_carries(p_p1, g_p1, cin_p1);

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_s2
        assign diff_nxt[gi*GRP_W +: GRP_W] =
            sum_p1[gi*GRP_W +: GRP_W] + {{(GRP_W-1){1'b0}}, carries[gi]};
    end

    assign ovf_nxt = (a15_p1 != b15_p1) && (diff_nxt[DATA_W-1] != a15_p1);

    // Stage 1 operand data; loaded whenever stage 1 may advance.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            sum_p1 <= raw_sum;
            p_p1   <= grp_p;
            g_p1   <= grp_g;
            cin_p1 <= !bus.bin;
            a15_p1 <= bus.a[DATA_W-1];
            b15_p1 <= bus.b[DATA_W-1];
        end
    end

    // Valid bits and the output register; cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            diff_p2 <= '0;
            bout_p2 <= 1'b0;
            ovf_p2  <= 1'b0;
            zero_p2 <= 1'b0;
        end else begin
            if (s1_load) begin
                vld_p1 <= in_fire;
            end
            if (s2_load) begin
                vld_p2  <= vld_p1;
                diff_p2 <= diff_nxt;
                bout_p2 <= !carries[NGRP];
                ovf_p2  <= ovf_nxt;
                zero_p2 <= (diff_nxt == '0);
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.diff      = diff_p2;
    assign bus.bout      = bout_p2;
    assign bus.ovf       = ovf_p2;
    assign bus.zero      = zero_p2;
endmodule

// File: tb/tb_scazator_16bit_pipe.sv
// Directed and random checks for the 16-bit pipelined subtractor.
module tb_scazator_16bit_pipe;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    scazator_16bit_pipe_if bus ();

    scazator_16bit_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {diff, bout, ovf, zero} from plain 17-bit subtraction.
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
        logic [16:0] full;
        logic [15:0] d;
        full = {1'b0, x} - {1'b0, y} - {16'b0, c};
        d    = full[15:0];
        return {d, full[16], (x[15] != y[15]) && (d[15] != x[15]), d == 16'h0000};
    endfunction

    task test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = 16'h0;
        bus.b = 16'h0;
        bus.bin = 1'b0;
        #2;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if ({bus.diff, bus.bout, bus.ovf, bus.zero} !== 19'h0) begin
            n_err++; $display("FAIL reset_outputs: got %h want 0",
                              {bus.diff, bus.bout, bus.ovf, bus.zero});
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task test_arith;
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic        vc [8];
        logic [18:0] ve [8];
        va = '{16'h0005, 16'h0003, 16'h8000, 16'h7FFF, 16'h1234, 16'h0000, 16'hFFFF, 16'h1000};
        vb = '{16'h0003, 16'h0005, 16'h0001, 16'hFFFF, 16'h1233, 16'h0000, 16'h0001, 16'h0001};
        vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        // {diff, bout, ovf, zero}
        ve = '{{16'h0002, 3'b000}, {16'hFFFE, 3'b100}, {16'h7FFF, 3'b010},
               {16'h8000, 3'b110}, {16'h0000, 3'b001}, {16'hFFFF, 3'b100},
               {16'hFFFE, 3'b000}, {16'h0FFF, 3'b000}};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus.a = va[i];
            bus.b = vb[i];
            bus.bin = vc[i];
            bus.out_ready = 1'b1;
            bus.in_valid = 1'b1;
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin
                n_err++; $display("FAIL arith%0d_in_ready: got %b want 1", i, bus.in_ready);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_err++; $display("FAIL arith%0d_early_valid: got %b want 0", i, bus.out_valid);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_valid !== 1'b1) begin
                n_err++; $display("FAIL arith%0d_latency: got %b want 1", i, bus.out_valid);
            end
            n_cmp++;
            if ({bus.diff, bus.bout, bus.ovf, bus.zero} !== ve[i]) begin
                n_err++; $display("FAIL arith%0d_result: got %h want %h", i,
                                  {bus.diff, bus.bout, bus.ovf, bus.zero}, ve[i]);
            end
        end
    endtask

    task test_backpressure;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 16'h0010; bus.b = 16'h0001; bus.bin = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_accept0: got %b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.a = 16'h0100; bus.b = 16'h0010;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_accept1: got %b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.a = 16'h1000; bus.b = 16'h0100;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_full_in_ready: got %b want 0", bus.in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({bus.out_valid, bus.in_ready, bus.diff} !== {2'b10, 16'h000F}) begin
                n_err++; $display("FAIL bp_hold%0d: got valid=%b ready=%b diff=%h want 1 0 000f",
                                  k, bus.out_valid, bus.in_ready, bus.diff);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if ({bus.out_valid, bus.diff} !== {1'b1, 16'h00F0}) begin
            n_err++; $display("FAIL bp_second: got %b %h want 1 00f0", bus.out_valid, bus.diff);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.out_valid, bus.diff} !== {1'b1, 16'h0F00}) begin
            n_err++; $display("FAIL bp_third: got %b %h want 1 0f00", bus.out_valid, bus.diff);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_drained: got %b want 0", bus.out_valid);
        end
    endtask

    task test_reset_midflight;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 16'h7FFF; bus.b = 16'hFFFF; bus.bin = 1'b0;
        @(posedge clk); #1;
        bus.a = 16'h8000; bus.b = 16'h0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if ({bus.out_valid, bus.diff, bus.bout, bus.ovf} !== {1'b1, 16'h8000, 2'b11}) begin
            n_err++; $display("FAIL rst_prefill: got %b %h %b %b want 1 8000 1 1",
                              bus.out_valid, bus.diff, bus.bout, bus.ovf);
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_async_valid: got %b want 0", bus.out_valid);
        end
        n_cmp++;
        if ({bus.diff, bus.bout, bus.ovf, bus.zero, bus.in_ready} !== 20'h0) begin
            n_err++; $display("FAIL rst_async_outputs: got %h want 0",
                              {bus.diff, bus.bout, bus.ovf, bus.zero, bus.in_ready});
        end
        #10;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_err++; $display("FAIL rst_stale%0d: got %b want 0", k, bus.out_valid);
            end
        end
    endtask

    logic [18:0] sb_q [$];

    task test_random;
        int          accepted;
        int          received;
        int          cycles;
        logic [18:0] exp_v;
        accepted = 0;
        received = 0;
        cycles = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        while ((accepted < 10000 || sb_q.size() > 0) && cycles < 60000) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(model(bus.a, bus.b, bus.bin));
                accepted++;
            end
            if (bus.out_valid && bus.out_ready) begin
                received++;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++; $display("FAIL rand_extra: got %h want none",
                                      {bus.diff, bus.bout, bus.ovf, bus.zero});
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({bus.diff, bus.bout, bus.ovf, bus.zero} !== exp_v) begin
                        n_err++; $display("FAIL rand_result%0d: got %h want %h", received,
                                          {bus.diff, bus.bout, bus.ovf, bus.zero}, exp_v);
                    end
                end
            end
            @(posedge clk); #1;
            cycles++;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            bus.bin = 1'($urandom_range(0, 1));
            bus.in_valid = (accepted < 10000) && ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (cycles >= 60000) begin
            n_err++; $display("FAIL rand_timeout: got %0d cycles want < 60000", cycles);
        end
        n_cmp++;
        if (received != 10000) begin
            n_err++; $display("FAIL rand_count: got %0d want 10000", received);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_arith();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
